// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL lock/reset controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RST_HOLD   = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE_CHK = 3'd2,
        RUN        = 3'd3,
        CFG_SETTLE = 3'd4,
        FAIL       = 3'd5
    } pll_state_e;

    localparam logic [3:0] PSDA_DEFAULT   = 4'b0000;
    localparam logic [3:0] DUTYDA_DEFAULT = 4'b1000;

    // Bits needed for a counter that runs 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset hold, lock qualification with timeout/retry,
// downstream reset release and dynamic phase/duty updates with settle time.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC     = 270,
    parameter int LOCK_STABLE_CYC  = 2700,
    parameter int LOCK_TIMEOUT_CYC = 270000,
    parameter int SETTLE_CYC       = 64,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    input  logic       cfg_req,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ack,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output pll_state_e state
);

    localparam int HOLD_W   = cnt_width(RST_HOLD_CYC);
    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYC);
    localparam int TOUT_W   = cnt_width(LOCK_TIMEOUT_CYC);
    localparam int SETTLE_W = cnt_width(SETTLE_CYC);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TOUT_W-1:0]   TOUT_LAST   = TOUT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [1:0]          RETRY_LIMIT = 2'(MAX_RETRY);

    pll_state_e          next_state;
    logic                lock_s;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STABLE_W-1:0] stable_cnt;
    logic [TOUT_W-1:0]   tout_cnt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                hold_done;
    logic                stable_done;
    logic                tout_done;
    logic                settle_done;
    logic                locked_in;
    logic                timeout_hit;
    logic                cfg_accept;
    logic [1:0]          retry_next;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign hold_done   = (hold_cnt == HOLD_LAST);
    assign stable_done = (stable_cnt == STABLE_LAST);
    assign tout_done   = (tout_cnt == TOUT_LAST);
    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign retry_next  = retry_cnt + 2'd1;

    // A lock that qualifies on the last allowed cycle wins over the timeout.
    assign locked_in   = (state == STABLE_CHK) && lock_s && stable_done;
    assign timeout_hit = tout_done && !locked_in &&
                         ((state == WAIT_LOCK) || (state == STABLE_CHK));

    // cfg handshake: cfg_req is a level held by the requester until cfg_ack.
    // A request is taken only in RUN with lock present and cfg_ack low, so a
    // level still high in the ack cycle is ignored and counts again one cycle later.
    assign cfg_accept = (state == RUN) && lock_s && cfg_req && !cfg_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_HOLD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RST_HOLD: begin
                if (hold_done) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (timeout_hit)  next_state = (retry_next == RETRY_LIMIT) ? FAIL : RST_HOLD;
                else if (lock_s)  next_state = STABLE_CHK;
            end
            STABLE_CHK: begin
                if (locked_in)        next_state = RUN;
                else if (timeout_hit) next_state = (retry_next == RETRY_LIMIT) ? FAIL : RST_HOLD;
                else if (!lock_s)     next_state = WAIT_LOCK;
            end
            RUN: begin
                if (!lock_s)         next_state = RST_HOLD;
                else if (cfg_accept) next_state = CFG_SETTLE;
            end
            CFG_SETTLE: begin
                if (!lock_s)          next_state = RST_HOLD;
                else if (settle_done) next_state = RUN;
            end
            FAIL:    next_state = FAIL;
            default: next_state = RST_HOLD;
        endcase
    end

    always_comb begin
        pll_reset = (state == RST_HOLD) || (state == FAIL);
        sys_rst_n = (state == RUN) || (state == CFG_SETTLE);
        ready     = (state == RUN);
        fail      = (state == FAIL);
    end

    // Counters idle at zero outside their own state, so every entry starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            stable_cnt <= '0;
            tout_cnt   <= '0;
            settle_cnt <= '0;
            cfg_ack    <= 1'b0;
            retry_cnt  <= 2'd0;
            psda       <= PSDA_DEFAULT;
            dutyda     <= DUTYDA_DEFAULT;
        end else begin
            hold_cnt   <= ((state == RST_HOLD) && !hold_done) ? hold_cnt + 1'b1 : '0;
            stable_cnt <= ((state == STABLE_CHK) && lock_s && !stable_done) ?
                          stable_cnt + 1'b1 : '0;
            tout_cnt   <= (((state == WAIT_LOCK) || (state == STABLE_CHK)) && !tout_done) ?
                          tout_cnt + 1'b1 : '0;
            settle_cnt <= ((state == CFG_SETTLE) && !settle_done) ? settle_cnt + 1'b1 : '0;
            cfg_ack    <= (state == CFG_SETTLE) && lock_s && settle_done;

            if (cfg_accept) begin
                psda   <= cfg_psda;
                dutyda <= cfg_dutyda;
            end

            if (timeout_hit) begin
                retry_cnt <= retry_next;
            end else if (locked_in) begin
                retry_cnt <= 2'd0;
            end
        end
    end

endmodule
